// File: rtl/half_adder.sv
// Half adder with a combinational sum/carry, a registered copy qualified by i_valid,
// and optional saturating event counters enabled by the HALF_ADDER_STATS_EN macro.
module half_adder #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_a,
    input  logic             i_b,
    input  logic             i_valid,
    input  logic             i_clr,
    output logic             sum,
    output logic             carry,
    output logic             o_sum_q,
    output logic             o_carry_q,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_op_cnt,
    output logic [CNT_W-1:0] o_carry_cnt
);

    // Pure operators so X/Z on the addends propagates rather than being masked.
    assign sum   = i_a ^ i_b;
    assign carry = i_a & i_b;

    logic sum_q_r;
    logic carry_q_r;
    logic valid_r;

    // Registered result: loads on valid, otherwise holds data and drops the qualifier.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sum_q_r   <= 1'b0;
            carry_q_r <= 1'b0;
            valid_r   <= 1'b0;
        end else if (i_valid) begin
            sum_q_r   <= sum;
            carry_q_r <= carry;
            valid_r   <= 1'b1;
        end else begin
            valid_r   <= 1'b0;
        end
    end

    assign o_sum_q   = sum_q_r;
    assign o_carry_q = carry_q_r;
    assign o_valid   = valid_r;

`ifdef HALF_ADDER_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (&value) begin
            return value;
        end else begin
            return value + CNT_W'(1);
        end
    endfunction

    logic [CNT_W-1:0] op_cnt_r;
    logic [CNT_W-1:0] carry_cnt_r;
    logic [CNT_W-1:0] op_cnt_next_s;
    logic [CNT_W-1:0] carry_cnt_next_s;

    // Counter next state: clear has priority over a simultaneous accepted operation.
    always_comb begin
        op_cnt_next_s    = op_cnt_r;
        carry_cnt_next_s = carry_cnt_r;
        if (i_clr) begin
            op_cnt_next_s    = '0;
            carry_cnt_next_s = '0;
        end else if (i_valid) begin
            op_cnt_next_s = sat_inc(op_cnt_r);
            if (carry) begin
                carry_cnt_next_s = sat_inc(carry_cnt_r);
            end else begin
                carry_cnt_next_s = carry_cnt_r;
            end
        end else begin
            op_cnt_next_s    = op_cnt_r;
            carry_cnt_next_s = carry_cnt_r;
        end
    end

    // Counter state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            op_cnt_r    <= '0;
            carry_cnt_r <= '0;
        end else begin
            op_cnt_r    <= op_cnt_next_s;
            carry_cnt_r <= carry_cnt_next_s;
        end
    end

    assign o_op_cnt    = op_cnt_r;
    assign o_carry_cnt = carry_cnt_r;
`else
    logic unused_clr_s;
    assign unused_clr_s = i_clr;
    assign o_op_cnt     = '0;
    assign o_carry_cnt  = '0;
`endif

endmodule

// File: tb/tb_half_adder.sv
// Directed, table-driven bench for half_adder; counter expectations follow HALF_ADDER_STATS_EN.
module tb_half_adder;

`ifdef HALF_ADDER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        rst_n;
    logic        a, b, valid, clr;
    logic        sum, carry, sum_q, carry_q, vld_q;
    logic [15:0] op_cnt, carry_cnt;
    logic        sum2, carry2, sum_q2, carry_q2, vld_q2;
    logic [1:0]  op_cnt2, carry_cnt2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic a;
        logic b;
        logic exp_sum;
        logic exp_carry;
    } vec_t;

    vec_t vecs [4];

    always #5 clk = clk_en ? ~clk : clk;

    half_adder #(.CNT_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_a(a), .i_b(b), .i_valid(valid), .i_clr(clr),
        .sum(sum), .carry(carry), .o_sum_q(sum_q), .o_carry_q(carry_q), .o_valid(vld_q),
        .o_op_cnt(op_cnt), .o_carry_cnt(carry_cnt)
    );

    half_adder #(.CNT_W(2)) dut_w2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_a(a), .i_b(b), .i_valid(valid), .i_clr(clr),
        .sum(sum2), .carry(carry2), .o_sum_q(sum_q2), .o_carry_q(carry_q2), .o_valid(vld_q2),
        .o_op_cnt(op_cnt2), .o_carry_cnt(carry_cnt2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic va, input logic vb, input logic vv, input logic vc);
        a = va; b = vb; valid = vv; clr = vc;
        tick();
    endtask

    initial begin
        logic ra, rb;
        logic [1:0] ref_v;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0; a = 1'b0; b = 1'b0; valid = 1'b0; clr = 1'b0;
        #1;
        chk("rst_sum_q", {31'd0, sum_q}, 32'd0);
        chk("rst_carry_q", {31'd0, carry_q}, 32'd0);
        chk("rst_valid", {31'd0, vld_q}, 32'd0);
        chk("rst_op_cnt", {16'd0, op_cnt}, 32'd0);
        chk("rst_carry_cnt", {16'd0, carry_cnt}, 32'd0);
        rst_n = 1'b1;
        #1;

        // Combinational check with the clock idle
        for (int i = 0; i < 4; i++) begin
            a = vecs[i].a; b = vecs[i].b;
            #1;
            chk($sformatf("comb_sum_%0d", i), {31'd0, sum}, {31'd0, vecs[i].exp_sum});
            chk($sformatf("comb_carry_%0d", i), {31'd0, carry}, {31'd0, vecs[i].exp_carry});
            #4;
        end
        for (int i = 0; i < 6; i++) begin
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            a = ra; b = rb;
            ref_v = {1'b0, ra} + {1'b0, rb};
            #5;
            chk($sformatf("rand_pair_%0d", i), {30'd0, carry, sum}, {30'd0, ref_v});
        end
        chk("idle_no_load", {31'd0, vld_q}, 32'd0);

        clk_en = 1'b1;
        a = 1'b0; b = 1'b0;
        tick();

        // Registered path: load then hold
        op(1'b1, 1'b1, 1'b1, 1'b0);
        chk("reg_sum_q", {31'd0, sum_q}, 32'd0);
        chk("reg_carry_q", {31'd0, carry_q}, 32'd1);
        chk("reg_valid", {31'd0, vld_q}, 32'd1);
        op(1'b0, 1'b1, 1'b0, 1'b0);
        chk("hold_valid", {31'd0, vld_q}, 32'd0);
        chk("hold_sum_q", {31'd0, sum_q}, 32'd0);
        chk("hold_carry_q", {31'd0, carry_q}, 32'd1);

        // Counters: clear, four ops, then clear racing a valid op
        op(1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_op_cnt", {16'd0, op_cnt}, 32'd0);
        for (int i = 0; i < 4; i++) op(vecs[i].a, vecs[i].b, 1'b1, 1'b0);
        chk("cnt_op", {16'd0, op_cnt}, STATS ? 32'd4 : 32'd0);
        chk("cnt_carry", {16'd0, carry_cnt}, STATS ? 32'd1 : 32'd0);
        chk("cnt_last_sum_q", {31'd0, sum_q}, 32'd0);
        op(1'b1, 1'b1, 1'b1, 1'b1);
        chk("clrv_op_cnt", {16'd0, op_cnt}, 32'd0);
        chk("clrv_carry_cnt", {16'd0, carry_cnt}, 32'd0);
        chk("clrv_carry_q", {31'd0, carry_q}, 32'd1);
        chk("clrv_valid", {31'd0, vld_q}, 32'd1);

        // Saturation on the narrow instance
        for (int i = 0; i < 5; i++) op(1'b1, 1'b1, 1'b1, 1'b0);
        chk("sat_op_cnt_w2", {30'd0, op_cnt2}, STATS ? 32'd3 : 32'd0);
        chk("sat_carry_cnt_w2", {30'd0, carry_cnt2}, STATS ? 32'd3 : 32'd0);
        chk("sat_op_cnt_w16", {16'd0, op_cnt}, STATS ? 32'd5 : 32'd0);
        chk("sat_carry_cnt_w16", {16'd0, carry_cnt}, STATS ? 32'd5 : 32'd0);

        // Async reset between edges after three ops
        for (int i = 0; i < 3; i++) op(1'b1, 1'b0, 1'b1, 1'b0);
        chk("pre_rst_sum_q", {31'd0, sum_q}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sum_q", {31'd0, sum_q}, 32'd0);
        chk("arst_carry_q", {31'd0, carry_q}, 32'd0);
        chk("arst_valid", {31'd0, vld_q}, 32'd0);
        chk("arst_op_cnt", {16'd0, op_cnt}, 32'd0);
        chk("arst_carry_cnt", {16'd0, carry_cnt}, 32'd0);
        a = 1'b1; b = 1'b1;
        #1;
        chk("arst_comb", {30'd0, carry, sum}, 32'd2);
        #2;
        rst_n = 1'b1;
        op(1'b0, 1'b1, 1'b1, 1'b0);
        chk("post_rst_sum_q", {31'd0, sum_q}, 32'd1);
        chk("post_rst_valid", {31'd0, vld_q}, 32'd1);
        chk("post_rst_op_cnt", {16'd0, op_cnt}, STATS ? 32'd1 : 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
